// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_unit
// Brief   : Writeback/commit stage. Retires one instruction per cycle and
//           sequences exceptions, eret and TLB ops with pipeline flush.
// Revision: 1.0
// ============================================================================
module wb_commit_unit #(
    parameter int          TLBNUM     = 16,
    parameter int          IDX_W      = $clog2(TLBNUM),
    parameter logic [31:0] RETIRE_RST = 32'h0    // retire_cnt reset value (0 in normal use)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [31:0]      ms_result,
    input  logic [4:0]       ms_dest,
    input  logic [3:0]       ms_gr_we,
    input  logic [2:0]       ms_op,
    input  logic [7:0]       ms_c0_addr,
    input  logic             ms_ex,
    input  logic [4:0]       ms_excode,
    input  logic             ms_tlbp_hit,
    input  logic [IDX_W-1:0] ms_tlbp_idx,
    input  logic [31:0]      c0_rdata,
    input  logic [31:0]      c0_index,
    output logic [3:0]       rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             cp0_we,
    output logic [7:0]       cp0_addr,
    output logic [31:0]      cp0_wdata,
    output logic             ex_commit,
    output logic [4:0]       ex_code,
    output logic             eret_commit,
    output logic             tlb_we,
    output logic             tlb_re,
    output logic [IDX_W-1:0] tlb_index,
    output logic             tlbp_we,
    output logic [31:0]      tlbp_data,
    output logic             flush,
    output logic             refetch,
    output logic [31:0]      refetch_pc,
    output logic [31:0]      retire_cnt
);

    localparam logic [2:0] c_op_mfc0  = 3'd1;
    localparam logic [2:0] c_op_mtc0  = 3'd2;
    localparam logic [2:0] c_op_eret  = 3'd3;
    localparam logic [2:0] c_op_tlbp  = 3'd4;
    localparam logic [2:0] c_op_tlbr  = 3'd5;
    localparam logic [2:0] c_op_tlbwi = 3'd6;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_TLB   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]      r_pc;
    logic [31:0]      r_result;
    logic [4:0]       r_dest;
    logic [3:0]       r_gr_we;
    logic [2:0]       r_op;
    logic [7:0]       r_c0_addr;
    logic             r_ex;
    logic [4:0]       r_excode;
    logic             r_tlbp_hit;
    logic [IDX_W-1:0] r_tlbp_idx;
    logic [31:0]      r_retire_cnt;

    logic       w_allowin;
    logic [3:0] w_rf_we;
    logic       w_cp0_we;
    logic       w_ex_commit;
    logic       w_eret_commit;
    logic       w_tlb_we;
    logic       w_tlb_re;
    logic       w_tlbp_we;
    logic       w_flush;
    logic       w_refetch;
    logic       w_retire;
    logic       w_load;
    logic       w_unused;

    always_comb begin
        w_next        = r_state;
        w_allowin     = 1'b0;
        w_rf_we       = 4'h0;
        w_cp0_we      = 1'b0;
        w_ex_commit   = 1'b0;
        w_eret_commit = 1'b0;
        w_tlb_we      = 1'b0;
        w_tlb_re      = 1'b0;
        w_tlbp_we     = 1'b0;
        w_flush       = 1'b0;
        w_refetch     = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_allowin = 1'b1;
                if (ms_to_ws_valid) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (r_ex) begin
                    w_ex_commit = 1'b1;
                    w_flush     = 1'b1;
                    w_next      = S_DRAIN;
                end else if (r_op == c_op_eret) begin
                    w_eret_commit = 1'b1;
                    w_flush       = 1'b1;
                    w_retire      = 1'b1;
                    w_next        = S_DRAIN;
                end else if (r_op == c_op_tlbwi || r_op == c_op_tlbr) begin
                    // Retirement is counted in TLB, once the refetch is issued
                    w_tlb_we = (r_op == c_op_tlbwi);
                    w_tlb_re = (r_op == c_op_tlbr);
                    w_next   = S_TLB;
                end else begin
                    w_allowin = 1'b1;
                    w_rf_we   = r_gr_we;
                    w_cp0_we  = (r_op == c_op_mtc0);
                    w_tlbp_we = (r_op == c_op_tlbp);
                    w_retire  = 1'b1;
                    w_next    = ms_to_ws_valid ? S_HOLD : S_EMPTY;
                end
            end
            S_TLB: begin
                w_refetch = 1'b1;
                w_flush   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_EMPTY;
            end
            default: begin
                w_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_retire_cnt <= RETIRE_RST;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    // allowin is never raised alongside flush, so a flushing cycle cannot load
    assign w_load = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_pc       <= ms_pc;
            r_result   <= ms_result;
            r_dest     <= ms_dest;
            r_gr_we    <= ms_gr_we;
            r_op       <= ms_op;
            r_c0_addr  <= ms_c0_addr;
            r_ex       <= ms_ex;
            r_excode   <= ms_excode;
            r_tlbp_hit <= ms_tlbp_hit;
            r_tlbp_idx <= ms_tlbp_idx;
        end
    end

    assign ws_allowin  = w_allowin     && !reset;
    assign rf_we       = reset ? 4'h0 : w_rf_we;
    assign cp0_we      = w_cp0_we      && !reset;
    assign ex_commit   = w_ex_commit   && !reset;
    assign eret_commit = w_eret_commit && !reset;
    assign tlb_we      = w_tlb_we      && !reset;
    assign tlb_re      = w_tlb_re      && !reset;
    assign tlbp_we     = w_tlbp_we     && !reset;
    assign flush       = w_flush       && !reset;
    assign refetch     = w_refetch     && !reset;

    assign rf_waddr   = r_dest;
    assign rf_wdata   = (r_op == c_op_mfc0) ? c0_rdata : r_result;
    assign cp0_addr   = r_c0_addr;
    assign cp0_wdata  = r_result;
    assign ex_code    = r_excode;
    assign tlb_index  = c0_index[IDX_W-1:0];
    assign tlbp_data  = {~r_tlbp_hit, {(31-IDX_W){1'b0}}, r_tlbp_idx};
    assign refetch_pc = r_pc + 32'd4;
    assign retire_cnt = r_retire_cnt;

    assign w_unused = &{1'b0, c0_index[31:IDX_W]};

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_commit_unit
// Brief   : Self-checking bench for wb_commit_unit (TLBNUM=32 and TLBNUM=8).
// Revision: 1.0
// ============================================================================
module tb_wb_commit_unit;

    localparam logic [31:0] RST_B = 32'hFFFF_FFF8;
    localparam int          NV    = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_result;
    logic [4:0]  ms_dest;
    logic [3:0]  ms_gr_we;
    logic [2:0]  ms_op;
    logic [7:0]  ms_c0_addr;
    logic        ms_ex;
    logic [4:0]  ms_excode;
    logic        ms_tlbp_hit;
    logic [4:0]  ms_tlbp_idx;
    logic [31:0] c0_rdata;
    logic [31:0] c0_index;

    logic        ws_allowin_a, ws_allowin_b;
    logic [3:0]  rf_we_a, rf_we_b;
    logic [4:0]  rf_waddr_a, rf_waddr_b;
    logic [31:0] rf_wdata_a, rf_wdata_b;
    logic        cp0_we_a, cp0_we_b;
    logic [7:0]  cp0_addr_a, cp0_addr_b;
    logic [31:0] cp0_wdata_a, cp0_wdata_b;
    logic        ex_commit_a, ex_commit_b;
    logic [4:0]  ex_code_a, ex_code_b;
    logic        eret_commit_a, eret_commit_b;
    logic        tlb_we_a, tlb_we_b;
    logic        tlb_re_a, tlb_re_b;
    logic [4:0]  tlb_index_a;
    logic [2:0]  tlb_index_b;
    logic        tlbp_we_a, tlbp_we_b;
    logic [31:0] tlbp_data_a, tlbp_data_b;
    logic        flush_a, flush_b;
    logic        refetch_a, refetch_b;
    logic [31:0] refetch_pc_a, refetch_pc_b;
    logic [31:0] retire_cnt_a, retire_cnt_b;

    wb_commit_unit #(.TLBNUM(32)) dut_a (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin_a),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_op(ms_op), .ms_c0_addr(ms_c0_addr), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_tlbp_hit(ms_tlbp_hit), .ms_tlbp_idx(ms_tlbp_idx), .c0_rdata(c0_rdata),
        .c0_index(c0_index), .rf_we(rf_we_a), .rf_waddr(rf_waddr_a), .rf_wdata(rf_wdata_a),
        .cp0_we(cp0_we_a), .cp0_addr(cp0_addr_a), .cp0_wdata(cp0_wdata_a),
        .ex_commit(ex_commit_a), .ex_code(ex_code_a), .eret_commit(eret_commit_a),
        .tlb_we(tlb_we_a), .tlb_re(tlb_re_a), .tlb_index(tlb_index_a), .tlbp_we(tlbp_we_a),
        .tlbp_data(tlbp_data_a), .flush(flush_a), .refetch(refetch_a),
        .refetch_pc(refetch_pc_a), .retire_cnt(retire_cnt_a)
    );

    wb_commit_unit #(.TLBNUM(8), .RETIRE_RST(RST_B)) dut_b (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin_b),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_op(ms_op), .ms_c0_addr(ms_c0_addr), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_tlbp_hit(ms_tlbp_hit), .ms_tlbp_idx(ms_tlbp_idx[2:0]), .c0_rdata(c0_rdata),
        .c0_index(c0_index), .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b),
        .cp0_we(cp0_we_b), .cp0_addr(cp0_addr_b), .cp0_wdata(cp0_wdata_b),
        .ex_commit(ex_commit_b), .ex_code(ex_code_b), .eret_commit(eret_commit_b),
        .tlb_we(tlb_we_b), .tlb_re(tlb_re_b), .tlb_index(tlb_index_b), .tlbp_we(tlbp_we_b),
        .tlbp_data(tlbp_data_b), .flush(flush_b), .refetch(refetch_b),
        .refetch_pc(refetch_pc_b), .retire_cnt(retire_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic [3:0]  gr_we;
        logic [2:0]  op;
        logic [7:0]  c0a;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  we;
    } wr_t;

    vec_t        vecs[NV];
    wr_t         sbq[$];
    wr_t         mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] res,
                       input logic [4:0] dest, input logic [3:0] we, input logic [2:0] op,
                       input logic [7:0] c0a, input logic ex, input logic [4:0] exc,
                       input logic hit, input logic [4:0] idx);
        ms_to_ws_valid = v;   ms_pc      = pc;  ms_result = res;
        ms_dest        = dest; ms_gr_we  = we;  ms_op     = op;
        ms_c0_addr     = c0a;  ms_ex     = ex;  ms_excode = exc;
        ms_tlbp_hit    = hit;  ms_tlbp_idx = idx;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 32'h0, 5'd0, 4'h0, 3'd0, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Scoreboard: every GPR write the DUT performs must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && rf_we_a != 4'h0) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL rf_write_unexpected: got addr %0d data 0x%08h we 0x%h, required no write",
                         rf_waddr_a, rf_wdata_a, rf_we_a);
            end else begin
                mon_e = sbq.pop_front();
                if ({rf_waddr_a, rf_wdata_a, rf_we_a} !== {mon_e.a, mon_e.d, mon_e.we}) begin
                    n_err++;
                    $display("FAIL rf_write: got addr %0d data 0x%08h we 0x%h, required addr %0d data 0x%08h we 0x%h",
                             rf_waddr_a, rf_wdata_a, rf_we_a, mon_e.a, mon_e.d, mon_e.we);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_1234, 5'd5,  4'hF, 3'd0, 8'h00, 32'h0,         32'h0000_1234};
        vecs[1] = '{32'h0000_0104, 32'h0000_9999, 5'd8,  4'hF, 3'd1, 8'h60, 32'h0000_ABCD, 32'h0000_ABCD};
        vecs[2] = '{32'h0000_0108, 32'hDEAD_BEEF, 5'd31, 4'h1, 3'd0, 8'h00, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{32'h0000_010C, 32'h0000_0055, 5'd0,  4'h0, 3'd2, 8'h61, 32'h0,         32'h0};
        vecs[4] = '{32'h0000_0110, 32'h0F0F_0000, 5'd1,  4'hC, 3'd0, 8'h00, 32'h0,         32'h0F0F_0000};

        reset = 1'b1; idle(); c0_rdata = 32'h0; c0_index = 32'h0;
        step(); step();
        #1;
        chk("reset_allowin", 32'(ws_allowin_a), 32'd0);
        chk("reset_retire_cnt", retire_cnt_a, 32'd0);
        chk("reset_retire_cnt_b", retire_cnt_b, RST_B);
        reset = 1'b0;
        step();
        chk("empty_allowin", 32'(ws_allowin_a), 32'd1);
        exp_cnt = 32'd0;

        // Back-to-back commits from the vector table
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drv(1'b1, vecs[i].pc, vecs[i].result, vecs[i].dest, vecs[i].gr_we, vecs[i].op,
                    vecs[i].c0a, 1'b0, 5'd0, 1'b0, 5'd0);
                if (vecs[i].gr_we != 4'h0)
                    sbq.push_back('{vecs[i].dest, vecs[i].exp_wdata, vecs[i].gr_we});
            end else begin
                idle();
            end
            c0_rdata = 32'h0;
            if (i > 0) c0_rdata = vecs[i-1].rdata;
            #1;
            chk("vec_allowin", 32'(ws_allowin_a), 32'd1);
            chk("vec_retire_cnt", retire_cnt_a, exp_cnt);
            chk("vec_retire_cnt_b", retire_cnt_b, exp_cnt + RST_B);
            if (i > 0) begin
                chk("vec_cp0_we", 32'(cp0_we_a), (vecs[i-1].op == 3'd2) ? 32'd1 : 32'd0);
                chk("vec_flush", 32'(flush_a), 32'd0);
                if (vecs[i-1].op == 3'd2) begin
                    chk("vec_cp0_addr", 32'(cp0_addr_a), 32'(vecs[i-1].c0a));
                    chk("vec_cp0_wdata", cp0_wdata_a, vecs[i-1].result);
                end
            end
            step();
            if (i > 0) exp_cnt = exp_cnt + 32'd1;
        end
        c0_rdata = 32'h0;
        chk("table_retire_cnt", retire_cnt_a, 32'd5);

        // tlbwi: strobe, refetch, drain; valid input during TLB/DRAIN must be ignored
        drv(1'b1, 32'hBFC0_0100, 32'h0, 5'd0, 4'h0, 3'd6, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        c0_index = 32'h3;
        step();
        drv(1'b1, 32'h0000_0200, 32'h1, 5'd9, 4'hF, 3'd0, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("tlbwi_tlb_we", 32'(tlb_we_a), 32'd1);
        chk("tlbwi_tlb_re", 32'(tlb_re_a), 32'd0);
        chk("tlbwi_index", 32'(tlb_index_a), 32'd3);
        chk("tlbwi_allowin", 32'(ws_allowin_a), 32'd0);
        chk("tlbwi_refetch_early", 32'(refetch_a), 32'd0);
        step();
        #1;
        chk("tlb_refetch", 32'(refetch_a), 32'd1);
        chk("tlb_flush", 32'(flush_a), 32'd1);
        chk("tlb_refetch_pc", refetch_pc_a, 32'hBFC0_0104);
        chk("tlb_we_one_cycle", 32'(tlb_we_a), 32'd0);
        chk("tlb_allowin", 32'(ws_allowin_a), 32'd0);
        chk("tlb_retire_before", retire_cnt_a, exp_cnt);
        step();
        exp_cnt = exp_cnt + 32'd1;
        #1;
        chk("drain_allowin", 32'(ws_allowin_a), 32'd0);
        chk("drain_refetch", 32'(refetch_a), 32'd0);
        chk("drain_flush", 32'(flush_a), 32'd0);
        chk("drain_retire", retire_cnt_a, exp_cnt);
        step();
        idle();
        #1;
        chk("post_drain_allowin", 32'(ws_allowin_a), 32'd1);
        step();

        // Exception with a concurrent valid input
        drv(1'b1, 32'h0000_0300, 32'h42, 5'd3, 4'hF, 3'd0, 8'h0, 1'b1, 5'h0C, 1'b0, 5'd0);
        step();
        drv(1'b1, 32'h0000_0304, 32'h5A, 5'd4, 4'hF, 3'd0, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("ex_commit", 32'(ex_commit_a), 32'd1);
        chk("ex_code", 32'(ex_code_a), 32'h0C);
        chk("ex_rf_we", 32'(rf_we_a), 32'd0);
        chk("ex_flush", 32'(flush_a), 32'd1);
        chk("ex_allowin", 32'(ws_allowin_a), 32'd0);
        step();
        idle();
        #1;
        chk("ex_drain_commit", 32'(ex_commit_a), 32'd0);
        chk("ex_retire_unchanged", retire_cnt_a, exp_cnt);
        step();
        #1;
        chk("ex_empty_allowin", 32'(ws_allowin_a), 32'd1);
        step();

        // tlbp miss (TLBNUM=32) then hit (TLBNUM=8)
        drv(1'b1, 32'h0000_0400, 32'h0, 5'd0, 4'h0, 3'd4, 8'h0, 1'b0, 5'd0, 1'b0, 5'd7);
        step();
        idle();
        #1;
        chk("tlbp_miss_we", 32'(tlbp_we_a), 32'd1);
        chk("tlbp_miss_data", tlbp_data_a, 32'h8000_0007);
        step();
        exp_cnt = exp_cnt + 32'd1;
        drv(1'b1, 32'h0000_0404, 32'h0, 5'd0, 4'h0, 3'd4, 8'h0, 1'b0, 5'd0, 1'b1, 5'd7);
        step();
        idle();
        #1;
        chk("tlbp_hit_we_b", 32'(tlbp_we_b), 32'd1);
        chk("tlbp_hit_data_b", tlbp_data_b, 32'h0000_0007);
        step();
        exp_cnt = exp_cnt + 32'd1;
        #1;
        chk("wrap_retire_b", retire_cnt_b, 32'h0000_0000);
        chk("wrap_retire_a", retire_cnt_a, 32'd8);

        // eret
        drv(1'b1, 32'h0000_0500, 32'h0, 5'd0, 4'h0, 3'd3, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        #1;
        chk("eret_commit", 32'(eret_commit_a), 32'd1);
        chk("eret_flush", 32'(flush_a), 32'd1);
        chk("eret_allowin", 32'(ws_allowin_a), 32'd0);
        step();
        exp_cnt = exp_cnt + 32'd1;
        #1;
        chk("eret_drain_commit", 32'(eret_commit_a), 32'd0);
        chk("eret_retire_a", retire_cnt_a, 32'd9);
        chk("eret_retire_b", retire_cnt_b, 32'd1);
        step();

        // tlbr, then reset while in TLB
        drv(1'b1, 32'h0000_0600, 32'h0, 5'd0, 4'h0, 3'd5, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        #1;
        chk("tlbr_tlb_re", 32'(tlb_re_a), 32'd1);
        chk("tlbr_tlb_we", 32'(tlb_we_a), 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("rst_tlb_refetch", 32'(refetch_a), 32'd0);
        chk("rst_tlb_flush", 32'(flush_a), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_tlb_empty_allowin", 32'(ws_allowin_a), 32'd1);
        chk("rst_tlb_retire_a", retire_cnt_a, 32'd0);
        chk("rst_tlb_retire_b", retire_cnt_b, RST_B);
        chk("rst_tlb_no_refetch", 32'(refetch_a), 32'd0);

        // Normal commit after reset
        drv(1'b1, 32'h0000_0700, 32'h77, 5'd7, 4'hF, 3'd0, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        sbq.push_back('{5'd7, 32'h0000_0077, 4'hF});
        step();
        idle();
        #1;
        chk("post_rst_allowin", 32'(ws_allowin_a), 32'd1);
        step();
        #1;
        chk("post_rst_retire", retire_cnt_a, 32'd1);
        step();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_unit.md
WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning TLB entry count; power of two, 2..64.
REQ-002 SHALL have derived parameter IDX_W, default clog2(TLBNUM), meaning TLB index width.
REQ-003 SHALL have the following ports, with reset reset, synchronous, active-high, and clock clk:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ms_to_ws_valid  in  1  upstream valid
- ws_allowin  out  1  accept strobe
- ms_pc  in  32  instruction PC
- ms_result  in  32  ALU/load result, or mtc0 data
- ms_dest  in  5  destination GPR
- ms_gr_we  in  4  byte write enables
- ms_op  in  3  0 none, 1 mfc0, 2 mtc0, 3 eret, 4 tlbp, 5 tlbr, 6 tlbwi
- ms_c0_addr  in  8  CP0 {reg,sel}
- ms_ex  in  1  exception flag
- ms_excode  in  5  exception code
- ms_tlbp_hit  in  1  tlbp hit
- ms_tlbp_idx  in  IDX_W  tlbp index
- c0_rdata  in  32  CP0 read data for cp0_addr, combinational
- c0_index  in  32  CP0 Index register
- rf_we  out  4  GPR byte enables
- rf_waddr  out  5  GPR address
- rf_wdata  out  32  GPR data
- cp0_we  out  1  mtc0 write
- cp0_addr  out  8  CP0 address
- cp0_wdata  out  32  CP0 write data
- ex_commit  out  1  exception commit pulse
- ex_code  out  5  committed excode
- eret_commit  out  1  eret commit pulse
- tlb_we  out  1  TLB write strobe
- tlb_re  out  1  TLB read strobe; CP0 latches read data
- tlb_index  out  IDX_W  c0_index[IDX_W-1:0]
- tlbp_we  out  1  Index-register write
- tlbp_data  out  32  {~hit, 31-IDX_W zeros, idx}
- flush  out  1  kill all upstream stages
- refetch  out  1  redirect fetch
- refetch_pc  out  32  ms_pc latched + 4
- retire_cnt  out  32  committed-instruction count

Function
REQ-004 SHALL hold one instruction in a payload register loaded only when ms_to_ws_valid && ws_allowin.
REQ-005 SHALL implement FSM states EMPTY, HOLD, TLB, DRAIN; reset state EMPTY.
REQ-006 EMPTY: ws_allowin=1; valid input -> HOLD; otherwise stay in EMPTY.
REQ-007 HOLD, ex=0, op not tlbr/tlbwi: commit this cycle, ws_allowin=1; next state HOLD if valid input, else EMPTY.
REQ-008 Commit effects: rf_we=gr_we; rf_wdata=c0_rdata for mfc0, else result; cp0_we=1 for mtc0; tlbp_we=1 for tlbp; retire_cnt+1.
REQ-009 HOLD, ex=1: ex_commit=1, ex_code=excode, flush=1; rf_we=0, cp0_we=0, tlb strobes 0; retire_cnt unchanged; next state DRAIN.
REQ-010 HOLD, op=eret, ex=0: eret_commit=1, flush=1, retire_cnt+1; next state DRAIN.
REQ-011 HOLD, op=tlbwi/tlbr, ex=0: tlb_we or tlb_re for exactly 1 cycle, ws_allowin=0; next state TLB.
REQ-012 TLB: refetch=1, flush=1, retire_cnt+1; next state DRAIN; ws_allowin=0.
REQ-013 DRAIN: ws_allowin=0, all strobes 0, ms_to_ws_valid ignored; next state EMPTY.
REQ-014 A valid input presented in the same cycle as flush SHALL NOT be latched.
REQ-015 All pulse outputs SHALL be 0 in EMPTY and DRAIN; rf_waddr, cp0_addr and cp0_wdata SHALL follow the payload register.
REQ-016 retire_cnt SHALL wrap from 0xFFFFFFFF to 0; refetch_pc SHALL be computed mod 2^32.

Reset
REQ-017 Reset SHALL force state EMPTY and retire_cnt=0, and drive every strobe output 0 in the same cycle.
REQ-018 Reset asserted in TLB state SHALL suppress refetch and flush; payload contents are don't-care after reset.

Verification
REQ-019 add to r5, result 0x1234, gr_we=F, back-to-back with next valid -> rf_we=F, rf_waddr=5, rf_wdata=0x1234 in one cycle; allowin stays 1.
REQ-020 mfc0 addr 0x60, c0_rdata=0xABCD -> rf_wdata=0xABCD; retire_cnt increments by 1.
REQ-021 tlbwi at pc 0xBFC00100, c0_index=0x3 -> tlb_we=1, tlb_index=3, for 1 cycle; next cycle refetch=1 with refetch_pc=0xBFC00104; then one DRAIN cycle with allowin=0.
REQ-022 ex=1 with excode 0x0C and gr_we=F -> ex_commit=1, rf_we=0, flush=1; a concurrent valid input is not latched; retire_cnt unchanged.
REQ-023 tlbp miss with TLBNUM=32, idx=7 -> tlbp_data=0x80000007; re-run with TLBNUM=8 and hit -> tlbp_data=0x00000007.
REQ-024 retire_cnt preloaded near 0xFFFFFFFF, then commit -> wraps to 0; reset asserted in TLB state -> no refetch, state EMPTY.
